and32: RTL and testbench

AND32 -- requirements
Module: and32

---
 rtl/and32.sv | 53 +++++
 tb/tb_and32.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/and32.sv
// 32-bit bitwise AND with combinational and registered results.
// Ports: clk, rst_n (sync, active-low), a, b, in_valid -> out (comb),
//   out_q, out_valid, zero, ones, popcnt, parity (registered).
module and32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic [31:0] out,
  output logic [31:0] out_q,
  output logic        out_valid,
  output logic        zero,
  output logic        ones,
  output logic [5:0]  popcnt,
  output logic        parity
);

  logic [31:0] res;
  logic [5:0]  cnt;

  assign res = a & b;
  assign out = res;

  // 6-bit count so an all-ones result reads 32 without wrapping
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, res[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
      ones      <= 1'b0;
      popcnt    <= '0;
      parity    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q  <= res;
        zero   <= (res == '0);
        ones   <= (res == '1);
        popcnt <= cnt;
        parity <= ^res;
      end
    end
  end

endmodule

// File: tb/tb_and32.sv
// Self-checking bench for and32: literal checks plus a
// randomized sweep against a behavioural model.
module tb_and32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        out_valid;
  logic        zero;
  logic        ones;
  logic [5:0]  popcnt;
  logic        parity;

  int n_chk = 0;
  int n_fail = 0;

  and32 dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .out(out),
    .out_q(out_q),
    .out_valid(out_valid),
    .zero(zero),
    .ones(ones),
    .popcnt(popcnt),
    .parity(parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: last captured result and whether a capture just happened
  logic [31:0] m_q;
  logic        m_v;
  bit          m_init = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q = 32'd0;
      m_v = 1'b0;
      m_init = 1;
    end else if (in_valid) begin
      m_q = a & b;
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  end

  function automatic int count_ones(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      int c;
      c = count_ones(m_q);
      chk("m_out", out, a & b);
      chk("m_out_q", out_q, m_q);
      chk("m_valid", {31'd0, out_valid}, {31'd0, m_v});
      chk("m_zero", {31'd0, zero}, (c == 0) ? 1 : 0);
      chk("m_ones", {31'd0, ones}, (c == 32) ? 1 : 0);
      chk("m_popcnt", {26'd0, popcnt}, c);
      chk("m_parity", {31'd0, parity}, c % 2);
      chk("m_excl", {31'd0, zero & ones}, 0);
    end
  end

  // Apply inputs, let one rising edge pass, return 1 time unit after it
  task automatic cycle(input logic [31:0] ta, input logic [31:0] tb,
                       input logic v, input logic r);
    a = ta;
    b = tb;
    in_valid = v;
    rst_n = r;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string nm, input logic [31:0] q,
                          input logic v, input logic z,
                          input logic o, input logic [5:0] pc,
                          input logic p);
    chk({nm, "_out_q"}, out_q, q);
    chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({nm, "_ones"}, {31'd0, ones}, {31'd0, o});
    chk({nm, "_popcnt"}, {26'd0, popcnt}, {26'd0, pc});
    chk({nm, "_parity"}, {31'd0, parity}, {31'd0, p});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    a = '1;
    b = '1;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;

    // Reset with a valid pair pending; out stays combinational
    cycle(32'hffffffff, 32'hffffffff, 1'b1, 1'b0);
    cycle(32'hffffffff, 32'hffffffff, 1'b1, 1'b0);
    chk("rst_out", out, 32'hffffffff);
    chk_regs("rst", 32'd0, 0, 1, 0, 6'd0, 0);

    // First capture on the first edge out of reset
    cycle(32'h0, 32'h0, 1'b1, 1'b1);
    chk("zero_out", out, 32'h0);
    chk_regs("zcap", 32'd0, 1, 1, 0, 6'd0, 0);

    cycle(32'hffffffff, 32'hffffffff, 1'b1, 1'b1);
    chk("ones_out", out, 32'hffffffff);
    chk_regs("ocap", 32'hffffffff, 1, 0, 1, 6'd32, 0);

    cycle(32'he9eec208, 32'h583bd1cc, 1'b1, 1'b1);
    chk("mix_out", out, 32'h482ac008);
    chk_regs("mix", 32'h482ac008, 1, 0, 0, 6'd8, 0);

    // No capture: out follows at once, registers hold
    a = 32'h1fbc8148;
    b = 32'h20ce01ee;
    in_valid = 1'b0;
    #1;
    chk("hold_out", out, 32'h008c0148);
    cycle(32'h1fbc8148, 32'h20ce01ee, 1'b0, 1'b1);
    chk_regs("hold", 32'h482ac008, 0, 0, 0, 6'd8, 0);

    // Two back-to-back captures, then reset drops a pending pair
    cycle(32'h0000ffff, 32'h00ff00ff, 1'b1, 1'b1);
    chk_regs("b2b1", 32'h000000ff, 1, 0, 0, 6'd8, 0);
    cycle(32'h12345678, 32'hffffffff, 1'b1, 1'b1);
    chk_regs("b2b2", 32'h12345678, 1, 0, 0, 6'd13, 1);
    cycle(32'hdeadbeef, 32'hffffffff, 1'b1, 1'b0);
    chk_regs("rst2", 32'd0, 0, 1, 0, 6'd0, 0);
    cycle(32'hdeadbeef, 32'hffffffff, 1'b0, 1'b1);
    chk_regs("drop", 32'd0, 0, 1, 0, 6'd0, 0);

    // Random sweep; occasional all-ones/zero operands and resets
    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: begin ra = '1; rb = '1; end
        1: rb = '1;
        2: ra = '0;
        default: ;
      endcase
      cycle(ra, rb, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) != 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
